// File: rtl/instr_line_fill.sv
// Line-fill stage feeding instruction fetch: assembles one 8-word line over a 32-bit valid/ready bus.
// Optional bus-error abort reporting is enabled by defining IFILL_BUS_ERR_EN.
module instr_line_fill #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned LINE_WORDS = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         fetch_req,
    input  logic [XLEN-1:0]              fetch_addr,
    input  logic                         flush,
    output logic [XLEN*LINE_WORDS-1:0]   line_data,
    output logic                         line_valid,
    output logic [XLEN-$clog2(LINE_WORDS)-3:0] line_tag,
    output logic                         busy,
    output logic                         mem_req_valid,
    output logic [XLEN-1:0]              mem_req_addr,
    input  logic                         mem_req_ready,
    input  logic                         mem_rsp_valid,
    input  logic [XLEN-1:0]              mem_rsp_data,
    input  logic                         mem_rsp_err,
    output logic                         line_error
);

    localparam int unsigned IdxW  = $clog2(LINE_WORDS);
    localparam int unsigned OffW  = IdxW + 2;
    localparam int unsigned TagW  = XLEN - OffW;
    localparam int unsigned LineW = XLEN * LINE_WORDS;

    typedef enum logic [1:0] {StIdle, StIssue, StWaitRsp, StDrain} state_e;

    state_e            state_q, state_d;
    logic [LineW-1:0]  line_q, line_d;
    logic              valid_q, valid_d;
    logic [TagW-1:0]   tag_q, tag_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic              abort_q, abort_d;
    logic              hit;
    logic [IdxW-1:0]   slot;

`ifdef IFILL_BUS_ERR_EN
    logic              err_q, err_d;
    logic [OffW-1:0]   unused_off;
    assign unused_off = fetch_addr[OffW-1:0];
`else
    logic [OffW:0]     unused_bits;
    assign unused_bits = {fetch_addr[OffW-1:0], mem_rsp_err};
`endif

    assign hit  = fetch_req & valid_q & (fetch_addr[XLEN-1:OffW] == tag_q);
    // Word 0 of the line sits in the most significant slot.
    assign slot = IdxW'(LINE_WORDS - 1) - idx_q;

    always_comb begin
        state_d = state_q;
        line_d  = line_q;
        valid_d = valid_q;
        tag_d   = tag_q;
        idx_d   = idx_q;
        abort_d = abort_q;
`ifdef IFILL_BUS_ERR_EN
        err_d   = err_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (flush) begin
`ifdef IFILL_BUS_ERR_EN
                    err_d = 1'b0;
`endif
                end else if (fetch_req && !hit) begin
                    tag_d   = fetch_addr[XLEN-1:OffW];
                    valid_d = 1'b0;
                    idx_d   = '0;
                    abort_d = 1'b0;
                    state_d = StIssue;
`ifdef IFILL_BUS_ERR_EN
                    err_d   = 1'b0;
`endif
                end
            end
            StIssue: begin
                // The request cannot be withdrawn, so a flush here only arms the abort.
                if (flush) begin
                    abort_d = 1'b1;
                end
                if (mem_req_ready) begin
                    if (abort_q || flush) begin
                        abort_d = 1'b0;
                        state_d = StDrain;
                    end else begin
                        state_d = StWaitRsp;
                    end
                end
            end
            StWaitRsp: begin
                if (mem_rsp_valid) begin
                    if (flush) begin
                        // Response already consumed this cycle; nothing left to drain.
                        state_d = StIdle;
`ifdef IFILL_BUS_ERR_EN
                    end else if (mem_rsp_err) begin
                        err_d   = 1'b1;
                        state_d = StIdle;
`endif
                    end else begin
                        line_d[32'(slot)*XLEN +: XLEN] = mem_rsp_data;
                        if (idx_q == IdxW'(LINE_WORDS - 1)) begin
                            valid_d = 1'b1;
                            state_d = StIdle;
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            state_d = StIssue;
                        end
                    end
                end else if (flush) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (mem_rsp_valid) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            line_q  <= '0;
            valid_q <= 1'b0;
            tag_q   <= '0;
            idx_q   <= '0;
            abort_q <= 1'b0;
`ifdef IFILL_BUS_ERR_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            valid_q <= valid_d;
            tag_q   <= tag_d;
            idx_q   <= idx_d;
            abort_q <= abort_d;
`ifdef IFILL_BUS_ERR_EN
            err_q   <= err_d;
`endif
        end
    end

    assign line_data     = line_q;
    assign line_valid    = valid_q;
    assign line_tag      = tag_q;
    assign busy          = (state_q != StIdle);
    assign mem_req_valid = (state_q == StIssue);
    assign mem_req_addr  = {tag_q, idx_q, 2'b00};
`ifdef IFILL_BUS_ERR_EN
    assign line_error    = err_q;
`else
    assign line_error    = 1'b0;
`endif

endmodule

// File: tb/tb_instr_line_fill.sv
// Directed bench for instr_line_fill with a one-outstanding zero-wait memory model.
module tb_instr_line_fill;

    logic         clk = 1'b0;
    logic         reset;
    logic         fetch_req;
    logic [31:0]  fetch_addr;
    logic         flush;
    logic [255:0] line_data;
    logic         line_valid;
    logic [26:0]  line_tag;
    logic         busy;
    logic         mem_req_valid;
    logic [31:0]  mem_req_addr;
    logic         mem_req_ready;
    logic         mem_rsp_valid;
    logic [31:0]  mem_rsp_data;
    logic         mem_rsp_err;
    logic         line_error;

    always #5 clk = ~clk;

    instr_line_fill dut (
        .clk          (clk),
        .reset        (reset),
        .fetch_req    (fetch_req),
        .fetch_addr   (fetch_addr),
        .flush        (flush),
        .line_data    (line_data),
        .line_valid   (line_valid),
        .line_tag     (line_tag),
        .busy         (busy),
        .mem_req_valid(mem_req_valid),
        .mem_req_addr (mem_req_addr),
        .mem_req_ready(mem_req_ready),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data (mem_rsp_data),
        .mem_rsp_err  (mem_rsp_err),
        .line_error   (line_error)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] log_q[$];
    logic        pend;
    logic [31:0] pend_addr;
    logic        hold_rsp;
    logic [31:0] stall_addr;
    int          stall_left;
    logic [31:0] err_addr;
    int          n;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] exp_line(input logic [31:0] base);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[(7-i)*32 +: 32] = base + 32'(4*i);
        return r;
    endfunction

    // One cycle: at the falling edge, deliver the pending response and drive ready.
    task automatic cyc();
        @(negedge clk);
        if (hold_rsp) begin
            mem_rsp_valid = 1'b0;
            mem_rsp_err   = 1'b0;
        end else begin
            mem_rsp_valid = pend;
            mem_rsp_data  = pend_addr;
            mem_rsp_err   = pend && (pend_addr == err_addr);
            pend          = 1'b0;
        end
        if (mem_req_valid && mem_req_addr == stall_addr && stall_left > 0) begin
            mem_req_ready = 1'b0;
            stall_left--;
        end else begin
            mem_req_ready = 1'b1;
        end
        if (mem_req_valid && mem_req_ready) begin
            pend      = 1'b1;
            pend_addr = mem_req_addr;
            log_q.push_back(mem_req_addr);
        end
    endtask

    task automatic do_fill(input logic [31:0] a, output int cnt);
        fetch_req  = 1'b1;
        fetch_addr = a;
        log_q.delete();
        cnt = 0;
        while (cnt < 200) begin
            cyc();
            cnt++;
            if (line_valid || !busy) break;
        end
        fetch_req = 1'b0;
    endtask

    task automatic chk_log(input string tag, input logic [31:0] base);
        chk({tag, "_nreq"}, 256'(log_q.size()), 256'd8);
        if (log_q.size() == 8)
            for (int i = 0; i < 8; i++) chk({tag, "_req"}, 256'(log_q[i]), 256'(base + 32'(4*i)));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; fetch_req = 1'b0; fetch_addr = '0; flush = 1'b0;
        mem_req_ready = 1'b1; mem_rsp_valid = 1'b0; mem_rsp_data = '0; mem_rsp_err = 1'b0;
        pend = 1'b0; pend_addr = '0; hold_rsp = 1'b0;
        stall_addr = 32'h1; stall_left = 0; err_addr = 32'h1;
        cyc(); cyc();
        chk("rst_valid", 256'(line_valid), 256'd0);
        chk("rst_data", line_data, 256'd0);
        chk("rst_tag", 256'(line_tag), 256'd0);
        chk("rst_req", 256'(mem_req_valid), 256'd0);
        chk("rst_busy", 256'(busy), 256'd0);
        chk("rst_err", 256'(line_error), 256'd0);
        reset = 1'b0;

        // 1: reset held two cycles in the middle of a fill, then a stale response
        fetch_req = 1'b1; fetch_addr = 32'h100;
        repeat (5) cyc();
        chk("t1_midfill_busy", 256'(busy), 256'd1);
        reset = 1'b1; fetch_req = 1'b0;
        cyc();
        chk("t1_rst_valid", 256'(line_valid), 256'd0);
        chk("t1_rst_req", 256'(mem_req_valid), 256'd0);
        chk("t1_rst_busy", 256'(busy), 256'd0);
        cyc();
        reset = 1'b0; pend = 1'b1; pend_addr = 32'hDEAD_BEEC;
        log_q.delete();
        cyc(); cyc();
        chk("t1_stale_busy", 256'(busy), 256'd0);
        chk("t1_stale_valid", 256'(line_valid), 256'd0);
        chk("t1_stale_data", line_data, 256'd0);
        chk("t1_stale_tag", 256'(line_tag), 256'd0);
        chk("t1_stale_nreq", 256'(log_q.size()), 256'd0);

        // 2: zero-wait miss on 0x24, then a hit on 0x3C
        do_fill(32'h24, n);
        chk("t2_latency", 256'(n), 256'd17);
        chk("t2_valid", 256'(line_valid), 256'd1);
        chk("t2_tag", 256'(line_tag), 256'd1);
        chk("t2_data", line_data, {32'h20, 32'h24, 32'h28, 32'h2C, 32'h30, 32'h34, 32'h38, 32'h3C});
        chk_log("t2", 32'h20);
        fetch_req = 1'b1; fetch_addr = 32'h3C; log_q.delete();
        repeat (4) cyc();
        fetch_req = 1'b0;
        chk("t2_hit_nreq", 256'(log_q.size()), 256'd0);
        chk("t2_hit_busy", 256'(busy), 256'd0);
        chk("t2_hit_valid", 256'(line_valid), 256'd1);

        // 3: ready low for 5 cycles on word 4 of line 0x40
        stall_addr = 32'h50; stall_left = 5;
`ifndef IFILL_BUS_ERR_EN
        err_addr = 32'h48;
`endif
        do_fill(32'h4C, n);
        err_addr = 32'h1;
        chk("t3_latency", 256'(n), 256'd22);
        chk("t3_stalled", 256'(stall_left), 256'd0);
        chk("t3_valid", 256'(line_valid), 256'd1);
        chk("t3_tag", 256'(line_tag), 256'd2);
        chk("t3_data", line_data, exp_line(32'h40));
        chk("t3_err", 256'(line_error), 256'd0);
        chk_log("t3", 32'h40);

        // 4: flush while waiting for word 3's response of line 0x80
        fetch_req = 1'b1; fetch_addr = 32'h80; log_q.delete(); n = 0;
        while (log_q.size() < 4 && n < 200) begin
            cyc();
            n++;
        end
        chk("t4_reach_word3", 256'(log_q.size()), 256'd4);
        hold_rsp = 1'b1;
        cyc();
        chk("t4_wait_busy", 256'(busy), 256'd1);
        chk("t4_wait_noreq", 256'(mem_req_valid), 256'd0);
        flush = 1'b1; fetch_req = 1'b0;
        cyc();
        hold_rsp = 1'b0;
        chk("t4_drain_busy", 256'(busy), 256'd1);
        chk("t4_drain_valid", 256'(line_valid), 256'd0);
        cyc();
        flush = 1'b0;
        chk("t4_drain_hold", 256'(busy), 256'd1);
        cyc();
        chk("t4_idle_busy", 256'(busy), 256'd0);
        chk("t4_idle_valid", 256'(line_valid), 256'd0);
        repeat (2) cyc();
        chk("t4_nreq", 256'(log_q.size()), 256'd4);
        do_fill(32'h10, n);
        chk("t4_refill_latency", 256'(n), 256'd17);
        chk("t4_refill_tag", 256'(line_tag), 256'd0);
        chk("t4_refill_data", line_data, exp_line(32'h0));
        chk_log("t4_refill", 32'h0);

        // 5: top-of-memory line must not wrap to address 0
        do_fill(32'hFFFF_FFF0, n);
        repeat (3) cyc();
        chk("t5_tag", 256'(line_tag), 256'h7FF_FFFF);
        chk("t5_valid", 256'(line_valid), 256'd1);
        chk("t5_data", line_data, exp_line(32'hFFFF_FFE0));
        chk_log("t5", 32'hFFFF_FFE0);

`ifdef IFILL_BUS_ERR_EN
        // 6: bus error on word 2 of line 0x40, cleared by flush
        err_addr = 32'h48;
        do_fill(32'h40, n);
        err_addr = 32'h1;
        chk("t6_abort_cycle", 256'(n), 256'd7);
        chk("t6_err", 256'(line_error), 256'd1);
        chk("t6_valid", 256'(line_valid), 256'd0);
        chk("t6_busy", 256'(busy), 256'd0);
        chk("t6_tag", 256'(line_tag), 256'd2);
        chk("t6_nreq", 256'(log_q.size()), 256'd3);
        cyc();
        chk("t6_err_held", 256'(line_error), 256'd1);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk("t6_err_clear", 256'(line_error), 256'd0);
`else
        chk("t6_err_tied", 256'(line_error), 256'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
